// File: rtl/rgb2yuv_pkg.sv
// Shared types and Q1.14 colour-conversion coefficients for rgb_to_yuv422_stream.
// Limited-range tables exist only when RGB2YUV_LIMITED_RANGE_EN is defined.
package rgb2yuv_pkg;

    localparam int COEF_FRAC = 14;
    localparam int COEF_W    = 16;

    typedef enum logic {
        STD_601 = 1'b0,
        STD_709 = 1'b1
    } std_e;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef struct packed {
        coef_t r;
        coef_t g;
        coef_t b;
    } coef_row_t;

    typedef struct packed {
        coef_row_t y;
        coef_row_t u;
        coef_row_t v;
    } coef_set_t;

    localparam coef_set_t FULL_601 = '{
        y: '{r:  16'sd4899, g:  16'sd9617, b:  16'sd1868},
        u: '{r: -16'sd2765, g: -16'sd5427, b:  16'sd8192},
        v: '{r:  16'sd8192, g: -16'sd6860, b: -16'sd1332}
    };

    localparam coef_set_t FULL_709 = '{
        y: '{r:  16'sd3483, g:  16'sd11718, b:  16'sd1183},
        u: '{r: -16'sd1877, g: -16'sd6315,  b:  16'sd8192},
        v: '{r:  16'sd8192, g: -16'sd7441,  b: -16'sd751}
    };

`ifdef RGB2YUV_LIMITED_RANGE_EN
    // Full-range sets scaled by 219/255 (Y) and 224/255 (chroma), rounded to nearest.
    localparam coef_set_t LIM_601 = '{
        y: '{r:  16'sd4207, g:  16'sd8259, b:  16'sd1604},
        u: '{r: -16'sd2429, g: -16'sd4767, b:  16'sd7196},
        v: '{r:  16'sd7196, g: -16'sd6026, b: -16'sd1170}
    };

    localparam coef_set_t LIM_709 = '{
        y: '{r:  16'sd2991, g:  16'sd10064, b:  16'sd1016},
        u: '{r: -16'sd1649, g: -16'sd5547,  b:  16'sd7196},
        v: '{r:  16'sd7196, g: -16'sd6536,  b: -16'sd660}
    };
`endif

    function automatic coef_set_t coef_sel(input std_e s);
`ifdef RGB2YUV_LIMITED_RANGE_EN
        return (s == STD_709) ? LIM_709 : LIM_601;
`else
        return (s == STD_709) ? FULL_709 : FULL_601;
`endif
    endfunction

endpackage

// File: rtl/rgb_to_yuv422_pixel.sv
// One pixel's products -> sums+round -> shift/offset/clamp datapath (3 register stages).
// Offsets and clamp limits follow RGB2YUV_LIMITED_RANGE_EN when defined.
module rgb2yuv_pixel
    import rgb2yuv_pkg::*;
#(
    parameter int IN_CH_WIDTH  = 16,
    parameter int OUT_CH_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [IN_CH_WIDTH-1:0]    r,
    input  logic [IN_CH_WIDTH-1:0]    g,
    input  logic [IN_CH_WIDTH-1:0]    b,
    input  coef_set_t                 coefs,
    input  logic                      csel,
    input  logic                      load,
    output logic [2*OUT_CH_WIDTH-1:0] yuv
);

    localparam int PW = COEF_W + IN_CH_WIDTH + 1;
    localparam int SW = PW + 2;
    localparam int S  = COEF_FRAC + IN_CH_WIDTH - OUT_CH_WIDTH;

    localparam logic signed [SW-1:0] ROUND = {{(SW-1){1'b0}}, 1'b1} << (S - 1);

`ifdef RGB2YUV_LIMITED_RANGE_EN
    localparam int Y_OFF_I = 16 << (OUT_CH_WIDTH - 8);
    localparam int Y_MIN_I = 16 << (OUT_CH_WIDTH - 8);
    localparam int Y_MAX_I = 235 << (OUT_CH_WIDTH - 8);
    localparam int C_MIN_I = 16 << (OUT_CH_WIDTH - 8);
    localparam int C_MAX_I = 240 << (OUT_CH_WIDTH - 8);
`else
    localparam int Y_OFF_I = 0;
    localparam int Y_MIN_I = 0;
    localparam int Y_MAX_I = (1 << OUT_CH_WIDTH) - 1;
    localparam int C_MIN_I = 0;
    localparam int C_MAX_I = (1 << OUT_CH_WIDTH) - 1;
`endif
    localparam int C_OFF_I = 1 << (OUT_CH_WIDTH - 1);

    function automatic logic signed [PW-1:0] sx(input coef_t c);
        return {{(PW-COEF_W){c[COEF_W-1]}}, c};
    endfunction

    function automatic logic [OUT_CH_WIDTH-1:0] clamp(input logic signed [SW-1:0] v,
                                                      input int lo, input int hi);
        if (v < SW'(lo)) begin
            return OUT_CH_WIDTH'(lo);
        end else if (v > SW'(hi)) begin
            return OUT_CH_WIDTH'(hi);
        end
        return v[OUT_CH_WIDTH-1:0];
    endfunction

    coef_row_t            crow;
    logic signed [PW-1:0] r_s, g_s, b_s;
    logic signed [PW-1:0] py_r, py_g, py_b;
    logic signed [PW-1:0] pc_r, pc_g, pc_b;
    logic signed [SW-1:0] ys_q, cs_q;
    logic signed [SW-1:0] y_v, c_v;

    // Only the chroma this pixel emits is multiplied.
    assign crow = csel ? coefs.v : coefs.u;
    assign r_s  = PW'({1'b0, r});
    assign g_s  = PW'({1'b0, g});
    assign b_s  = PW'({1'b0, b});

    always_ff @(posedge clk) begin
        py_r <= sx(coefs.y.r) * r_s;
        py_g <= sx(coefs.y.g) * g_s;
        py_b <= sx(coefs.y.b) * b_s;
        pc_r <= sx(crow.r) * r_s;
        pc_g <= sx(crow.g) * g_s;
        pc_b <= sx(crow.b) * b_s;
    end

    always_ff @(posedge clk) begin
        ys_q <= SW'(py_r) + SW'(py_g) + SW'(py_b) + ROUND;
        cs_q <= SW'(pc_r) + SW'(pc_g) + SW'(pc_b) + ROUND;
    end

    assign y_v = (ys_q >>> S) + SW'(Y_OFF_I);
    assign c_v = (cs_q >>> S) + SW'(C_OFF_I);

    // Output word holds between valid beats; only the last stage is reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            yuv <= '0;
        end else if (load) begin
            yuv <= {clamp(y_v, Y_MIN_I, Y_MAX_I), clamp(c_v, C_MIN_I, C_MAX_I)};
        end
    end

endmodule

// File: rtl/rgb_to_yuv422_stream.sv
// Streaming RGB -> YUV 4:2:2 converter, fixed 4-cycle latency, per-line BT.601/BT.709.
// Optional limited-range output via RGB2YUV_LIMITED_RANGE_EN.
module rgb_to_yuv422_stream
    import rgb2yuv_pkg::*;
#(
    parameter int PIXELS_PER_CLK = 8,
    parameter int IN_CH_WIDTH    = 16,
    parameter int OUT_CH_WIDTH   = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [PIXELS_PER_CLK*3*IN_CH_WIDTH-1:0]  rgb_i,
    input  logic                                     rgb_valid_i,
    input  logic                                     line_start_i,
    input  logic                                     std_sel_i,
    output logic [PIXELS_PER_CLK*2*OUT_CH_WIDTH-1:0] yuv_o,
    output logic                                     yuv_valid_o,
    output logic                                     yuv_line_start_o
);

    localparam int  PIX_W = 3 * IN_CH_WIDTH;
    localparam int  OUT_W = 2 * OUT_CH_WIDTH;
    localparam logic ODD  = (PIXELS_PER_CLK % 2) == 1;

    logic                              phase_q;
    std_e                              std_q;
    std_e                              std_eff;
    logic                              phase0;
    logic [PIXELS_PER_CLK-1:0]         csel_d;

    logic [PIXELS_PER_CLK*PIX_W-1:0]   rgb_q;
    coef_set_t                         coef_q;
    logic [PIXELS_PER_CLK-1:0]         csel_q;
    logic                              v1, v2, v3;
    logic                              ls1, ls2, ls3;

    // A line-start beat uses the freshly sampled standard and restarts chroma at U.
    always_comb begin
        std_eff = std_q;
        phase0  = phase_q;
        if (line_start_i) begin
            std_eff = std_e'(std_sel_i);
            phase0  = 1'b0;
        end
    end

    always_comb begin
        csel_d = '0;
        for (int k = 0; k < PIXELS_PER_CLK; k++) begin
            csel_d[k] = phase0 ^ k[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            phase_q          <= 1'b0;
            std_q            <= STD_601;
            v1               <= 1'b0;
            v2               <= 1'b0;
            v3               <= 1'b0;
            ls1              <= 1'b0;
            ls2              <= 1'b0;
            ls3              <= 1'b0;
            yuv_valid_o      <= 1'b0;
            yuv_line_start_o <= 1'b0;
        end else begin
            v1               <= rgb_valid_i;
            ls1              <= rgb_valid_i & line_start_i;
            v2               <= v1;
            ls2              <= ls1;
            v3               <= v2;
            ls3              <= ls2;
            yuv_valid_o      <= v3;
            yuv_line_start_o <= ls3;
            if (rgb_valid_i) begin
                phase_q <= phase0 ^ ODD;
                std_q   <= std_eff;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rgb_valid_i) begin
            rgb_q  <= rgb_i;
            coef_q <= coef_sel(std_eff);
            csel_q <= csel_d;
        end
    end

    for (genvar k = 0; k < PIXELS_PER_CLK; k++) begin : g_pix
        logic [OUT_W-1:0] word;

        rgb2yuv_pixel #(
            .IN_CH_WIDTH (IN_CH_WIDTH),
            .OUT_CH_WIDTH(OUT_CH_WIDTH)
        ) u_pixel (
            .clk    (clk_i),
            .reset_n(reset_n_i),
            .r      (rgb_q[k*PIX_W + 2*IN_CH_WIDTH +: IN_CH_WIDTH]),
            .g      (rgb_q[k*PIX_W + IN_CH_WIDTH +: IN_CH_WIDTH]),
            .b      (rgb_q[k*PIX_W +: IN_CH_WIDTH]),
            .coefs  (coef_q),
            .csel   (csel_q[k]),
            .load   (v3),
            .yuv    (word)
        );

        assign yuv_o[k*OUT_W +: OUT_W] = word;
    end

endmodule

// File: tb/tb_rgb_to_yuv422_stream.sv
// Bench for rgb_to_yuv422_stream: default 8-pixel instance plus an odd 3-pixel instance,
// checked against a plain-arithmetic reference model.
module tb_rgb_to_yuv422_stream;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [383:0] rgb8;
    logic [107:0] rgb3;
    logic         rgb_valid;
    logic         line_start;
    logic         std_sel;
    logic [127:0] yuv8;
    logic [59:0]  yuv3;
    logic         val8, val3, ls8, ls3;

    int errors = 0;
    int checks = 0;

    // Q1.14 tables: per standard, {Yr,Yg,Yb, Ur,Ug,Ub, Vr,Vg,Vb}.
    localparam int COEF [2][9] = '{
        '{4899, 9617, 1868, -2765, -5427, 8192, 8192, -6860, -1332},
        '{3483, 11718, 1183, -1877, -6315, 8192, 8192, -7441, -751}
    };

    typedef struct {
        bit           v;
        bit           ls;
        logic [127:0] w8;
        logic [59:0]  w3;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] last8;
    logic [59:0]  last3;
    bit           m_std, m_ph8, m_ph3;
    int           pr[8], pg[8], pb[8];

    always #5 clk = ~clk;

    rgb_to_yuv422_stream dut8 (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .rgb_i           (rgb8),
        .rgb_valid_i     (rgb_valid),
        .line_start_i    (line_start),
        .std_sel_i       (std_sel),
        .yuv_o           (yuv8),
        .yuv_valid_o     (val8),
        .yuv_line_start_o(ls8)
    );

    rgb_to_yuv422_stream #(
        .PIXELS_PER_CLK(3),
        .IN_CH_WIDTH   (12),
        .OUT_CH_WIDTH  (10)
    ) dut3 (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .rgb_i           (rgb3),
        .rgb_valid_i     (rgb_valid),
        .line_start_i    (line_start),
        .std_sel_i       (std_sel),
        .yuv_o           (yuv3),
        .yuv_valid_o     (val3),
        .yuv_line_start_o(ls3)
    );

    // round(sum / 2^S) with ties toward +inf, i.e. floor((sum + 2^(S-1)) / 2^S)
    function automatic longint conv(input int r, input int g, input int b,
                                    input int kr, input int kg, input int kb,
                                    input int in_w, input int out_w);
        longint s, d, v, q;
        s = longint'(kr) * r + longint'(kg) * g + longint'(kb) * b;
        d = longint'(1) << (14 + in_w - out_w);
        v = s + d / 2;
        q = v / d;
        if (v < 0 && q * d != v) q = q - 1;
        return q;
    endfunction

    function automatic longint clip(input longint x, input int out_w);
        longint mx;
        mx = (longint'(1) << out_w) - 1;
        if (x < 0) return 0;
        if (x > mx) return mx;
        return x;
    endfunction

    function automatic longint pix_word(input int r, input int g, input int b,
                                        input bit std, input bit use_v,
                                        input int in_w, input int out_w);
        longint y, c;
        int     o;
        o = use_v ? 6 : 3;
        y = clip(conv(r, g, b, COEF[std][0], COEF[std][1], COEF[std][2], in_w, out_w), out_w);
        c = clip(conv(r, g, b, COEF[std][o], COEF[std][o+1], COEF[std][o+2], in_w, out_w)
                 + (longint'(1) << (out_w - 1)), out_w);
        return (y << out_w) | c;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pack_inputs();
        for (int k = 0; k < 8; k++) begin
            rgb8[k*48 +: 48] = {16'(pr[k]), 16'(pg[k]), 16'(pb[k])};
        end
        for (int k = 0; k < 3; k++) begin
            rgb3[k*36 +: 36] = {12'(pr[k] >> 4), 12'(pg[k] >> 4), 12'(pb[k] >> 4)};
        end
    endtask

    task automatic fill(input int r, input int g, input int b);
        for (int k = 0; k < 8; k++) begin
            pr[k] = r; pg[k] = g; pb[k] = b;
        end
    endtask

    task automatic fill_rand();
        int sel;
        for (int k = 0; k < 8; k++) begin
            sel = $urandom_range(0, 5);
            pr[k] = (sel == 0) ? 0 : (sel == 1) ? 65535 : $urandom_range(0, 65535);
            pg[k] = $urandom_range(0, 65535);
            pb[k] = (sel == 2) ? 65535 : $urandom_range(0, 65535);
        end
    endtask

    task automatic step(input bit v, input bit ls, input bit std);
        exp_t e;
        bit   ph8, ph3;
        rgb_valid  = v;
        line_start = ls;
        std_sel    = std;
        pack_inputs();
        e.v  = v;
        e.ls = v & ls;
        e.w8 = '0;
        e.w3 = '0;
        if (v) begin
            if (ls) m_std = std;
            ph8 = ls ? 1'b0 : m_ph8;
            ph3 = ls ? 1'b0 : m_ph3;
            for (int k = 0; k < 8; k++) begin
                e.w8[k*16 +: 16] = 16'(pix_word(pr[k], pg[k], pb[k], m_std,
                                                ph8 ^ bit'(k % 2), 16, 8));
            end
            for (int k = 0; k < 3; k++) begin
                e.w3[k*20 +: 20] = 20'(pix_word(pr[k] >> 4, pg[k] >> 4, pb[k] >> 4, m_std,
                                                ph3 ^ bit'(k % 2), 12, 10));
            end
            m_ph8 = ph8 ^ bit'(8 % 2);
            m_ph3 = ph3 ^ bit'(3 % 2);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.v) begin
            last8 = e.w8;
            last3 = e.w3;
        end
        chk("valid8", 128'(val8), 128'(e.v));
        chk("ls8",    128'(ls8),  128'(e.ls));
        chk("yuv8",   128'(yuv8), 128'(last8));
        chk("valid3", 128'(val3), 128'(e.v));
        chk("ls3",    128'(ls3),  128'(e.ls));
        chk("yuv3",   128'(yuv3), 128'(last3));
    endtask

    task automatic do_reset(input int cycles);
        exp_t idle;
        for (int c = 0; c < cycles; c++) begin
            reset_n    = 1'b0;
            rgb_valid  = 1'b1;
            line_start = 1'b1;
            std_sel    = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_valid8", 128'(val8), 128'(0));
            chk("rst_ls8",    128'(ls8),  128'(0));
            chk("rst_yuv8",   128'(yuv8), 128'(0));
            chk("rst_valid3", 128'(val3), 128'(0));
            chk("rst_yuv3",   128'(yuv3), 128'(0));
        end
        reset_n   = 1'b1;
        rgb_valid = 1'b0;
        idle.v  = 1'b0;
        idle.ls = 1'b0;
        idle.w8 = '0;
        idle.w3 = '0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(idle);
        last8 = '0;
        last3 = '0;
        m_std = 1'b0;
        m_ph8 = 1'b0;
        m_ph3 = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        rgb_valid  = 1'b0;
        line_start = 1'b0;
        std_sel    = 1'b0;
        rgb8       = '0;
        rgb3       = '0;
        do_reset(2);

        // Full-scale white, then black, with line starts.
        fill(65535, 65535, 65535);
        step(1, 1, 0);
        fill(0, 0, 0);
        step(0, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Pure red; BT.709 requested mid-line takes effect only at the next line start.
        fill(65535, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 1, 1);
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // A(line start), B, gap, C, D(line start): gaps must not advance chroma phase.
        fill_rand(); step(1, 1, 0);
        fill_rand(); step(1, 0, 0);
        fill_rand(); step(0, 0, 0);
        fill_rand(); step(1, 0, 0);
        fill_rand(); step(1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Three beats in flight under BT.709, then a one-cycle reset drops them.
        fill_rand(); step(1, 1, 1);
        fill_rand(); step(1, 0, 1);
        fill_rand(); step(1, 0, 1);
        do_reset(1);
        fill_rand(); step(1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        // Random traffic with gaps, line starts and standard changes.
        for (int i = 0; i < 300; i++) begin
            fill_rand();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
